// File: rtl/wave_stream_pkg.sv
// Shared types and default sizes for the wave RAM streamer block.
// Feature macro: WAVE_RAM_STREAMER_OFFSET_BIN_EN (consumed by wave_ram_streamer).
package wave_stream_pkg;

    localparam int WS_SAMPLE_W    = 16;
    localparam int WS_ADDR_W      = 13;
    localparam int WS_DEPTH_WORDS = 6000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } stream_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Show-ahead sample FIFO that accepts two entries per push (low half first)
// and releases one entry per pop; head is valid whenever empty is low.
module sample_fifo
    import wave_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int SAMPLE_W   = WS_SAMPLE_W,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                push2,
    input  logic [SAMPLE_W-1:0] push_lo,
    input  logic [SAMPLE_W-1:0] push_hi,
    input  logic                pop,
    output logic [SAMPLE_W-1:0] head,
    output logic                empty,
    output logic [CNT_W-1:0]    count
);

    logic [SAMPLE_W-1:0]   mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [PTR_W-1:0]      wr_ptr_hi;
    logic [FIFO_DEPTH-1:0] wr_lo_sel;
    logic [FIFO_DEPTH-1:0] wr_hi_sel;
    logic                  pop_ok;

    assign wr_ptr_hi = wr_ptr_reg + PTR_W'(1);
    assign pop_ok    = pop && (count_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_sel
            assign wr_lo_sel[gi] = push2 && (wr_ptr_reg == PTR_W'(gi));
            assign wr_hi_sel[gi] = push2 && (wr_ptr_hi == PTR_W'(gi));
        end
    endgenerate

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wr_lo_sel[i]) begin
                mem_reg[i] <= push_lo;
            end else if (wr_hi_sel[i]) begin
                mem_reg[i] <= push_hi;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push2) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(2);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'({push2, 1'b0}) - CNT_W'(pop_ok);
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/wave_ram_streamer.sv
// Avalon-MM read master that streams a RAM waveform region as 16-bit DAC samples.
// Define WAVE_RAM_STREAMER_OFFSET_BIN_EN to present samples in offset binary.
module wave_ram_streamer
    import wave_stream_pkg::*;
#(
    parameter int ADDR_W      = WS_ADDR_W,
    parameter int DEPTH_WORDS = WS_DEPTH_WORDS,
    parameter int FIFO_DEPTH  = 8,
    parameter int SAMPLE_W    = WS_SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   length,
    input  logic                loop,
    input  logic                sample_tick,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_read,
    input  logic [31:0]         avm_readdata,
    output logic [SAMPLE_W-1:0] dac_data,
    output logic                dac_valid,
    output logic                busy,
    output logic                underrun
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    stream_state_e       state_reg, state_next;
    logic                enable_d_reg;
    logic [ADDR_W-1:0]   start_cfg_reg;
    logic [ADDR_W-1:0]   length_cfg_reg;
    logic                loop_cfg_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   remaining_reg;
    logic [ADDR_W-1:0]   avm_address_reg;
    logic                avm_read_reg;
    logic                rd_pending_reg;
    logic                underrun_reg;
    logic [SAMPLE_W-1:0] dac_data_reg;
    logic                dac_valid_reg;

    logic                enable_rise;
    logic                abort;
    logic                space_ok;
    logic                issue;
    logic                push;
    logic                pop;
    logic                tick_underrun;
    logic [ADDR_W-1:0]   addr_wrap;
    logic [SAMPLE_W-1:0] fifo_head;
    logic [SAMPLE_W-1:0] dac_word;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    assign enable_rise = enable && !enable_d_reg;
    assign abort       = (state_reg != IDLE) && !enable;

    // Reserve room for the response already in flight plus the new one.
    assign space_ok = (int'(fifo_count) + (rd_pending_reg ? 4 : 2)) <= FIFO_DEPTH;
    assign issue    = (state_reg == FETCH) && enable && (remaining_reg != '0)
                      && !avm_read_reg && space_ok;

    assign push          = rd_pending_reg && !abort;
    assign pop           = sample_tick && !fifo_empty && !abort;
    assign tick_underrun = sample_tick && fifo_empty && (state_reg == FETCH) && !abort;

    assign addr_wrap = (addr_reg == ADDR_W'(DEPTH_WORDS - 1)) ? '0 : addr_reg + ADDR_W'(1);

    sample_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SAMPLE_W   (SAMPLE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .flush   (abort),
        .push2   (push),
        .push_lo (avm_readdata[SAMPLE_W-1:0]),
        .push_hi (avm_readdata[2*SAMPLE_W-1:SAMPLE_W]),
        .pop     (pop),
        .head    (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef WAVE_RAM_STREAMER_OFFSET_BIN_EN
    assign dac_word = {~fifo_head[SAMPLE_W-1], fifo_head[SAMPLE_W-2:0]};
`else
    assign dac_word = fifo_head;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (enable_rise) begin
                    state_next = (length == '0) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if ((remaining_reg == '0) && !avm_read_reg && !rd_pending_reg) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!enable || fifo_empty) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            enable_d_reg    <= 1'b0;
            start_cfg_reg   <= '0;
            length_cfg_reg  <= '0;
            loop_cfg_reg    <= 1'b0;
            addr_reg        <= '0;
            remaining_reg   <= '0;
            avm_address_reg <= '0;
            avm_read_reg    <= 1'b0;
            rd_pending_reg  <= 1'b0;
            underrun_reg    <= 1'b0;
            dac_data_reg    <= '0;
            dac_valid_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            enable_d_reg <= enable;

            if ((state_reg == IDLE) && enable_rise) begin
                start_cfg_reg  <= start_addr;
                length_cfg_reg <= length;
                loop_cfg_reg   <= loop;
                addr_reg       <= start_addr;
                remaining_reg  <= length;
            end else if (issue) begin
                avm_address_reg <= addr_reg;
                // Looping reloads on the last issued word so fetch continues without a gap.
                if ((remaining_reg == ADDR_W'(1)) && loop_cfg_reg) begin
                    addr_reg      <= start_cfg_reg;
                    remaining_reg <= length_cfg_reg;
                end else begin
                    addr_reg      <= addr_wrap;
                    remaining_reg <= remaining_reg - ADDR_W'(1);
                end
            end

            avm_read_reg   <= issue;
            rd_pending_reg <= avm_read_reg && !abort;

            if ((state_reg == IDLE) && enable_rise) begin
                underrun_reg <= 1'b0;
            end else if (tick_underrun) begin
                underrun_reg <= 1'b1;
            end

            dac_valid_reg <= pop;
            if (pop) begin
                dac_data_reg <= dac_word;
            end
        end
    end

    assign avm_address    = avm_address_reg;
    assign avm_read       = avm_read_reg;
    assign avm_chipselect = avm_read_reg;
    assign dac_data       = dac_data_reg;
    assign dac_valid      = dac_valid_reg;
    assign busy           = (state_reg != IDLE);
    assign underrun       = underrun_reg;

endmodule
